ex_slice: RTL and testbench

- Execute stage of the 5-stage pipelined CPU. Sits directly upstream of the memory stage and feeds its M, WB, flags, address, write-data and ALU inputs.
- Contains the ID/EX pipeline register, a single-cycle ALU, a flag register, and an iterative 16-cycle multiplier.
- Raises busy while a multiply runs so the hazard unit holds IF/ID and earlier stages.

---
 rtl/ex_slice.sv | 224 ++++++++++++++++++++++
 tb/tb_ex_slice.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_slice.sv
// Execute stage: ID/EX pipeline register, single-cycle ALU, flag register
// and an iterative shift-add multiplier that holds the pipeline via busy.
// Optional feature macro: EX_SAT_EN (saturating ADD/SUB on signed overflow).
module ex_slice #(
    parameter int MUL_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic [4:0]  EX_in,
    input  logic [1:0]  M_in,
    input  logic [6:0]  WB_in,
    input  logic [15:0] rs_in,
    input  logic [15:0] rt_in,
    input  logic [15:0] imm_in,
    output logic [15:0] ALU,
    output logic [15:0] addr,
    output logic [15:0] wdata,
    output logic [2:0]  flags,
    output logic [1:0]  M,
    output logic [6:0]  WB,
    output logic        busy
);

    localparam int CW = $clog2(MUL_CYCLES) + 1;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_NOR = 4'd3;
    localparam logic [3:0] OP_SLL = 4'd4;
    localparam logic [3:0] OP_SRL = 4'd5;
    localparam logic [3:0] OP_SRA = 4'd6;
    localparam logic [3:0] OP_LHB = 4'd7;
    localparam logic [3:0] OP_LLB = 4'd8;
    localparam logic [3:0] OP_MUL = 4'd9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_t;

    // ID/EX register fields
    logic [4:0]  ex_r;
    logic [1:0]  m_r;
    logic [6:0]  wb_r;
    logic [15:0] rs_r, rt_r, imm_r;
    logic        valid_r;

    logic [2:0]  flag_r;
    mul_state_t  state_r, state_s;
    logic [15:0] acc_r, mcand_r, mplier_r;
    logic [CW-1:0] cnt_r;

    logic [3:0]  op_s;
    logic [15:0] b_s, sum_s, diff_s, result_s;
    logic [3:0]  shamt_s;
    logic        add_ov_s, sub_ov_s;
    logic        upd_zn_s, upd_ov_s, ov_val_s;
    logic        mul_start_s, busy_s;
    logic [2:0]  flags_s;

    // Clamp an overflowed sum to the signed extreme indicated by operand A's sign.
    function automatic logic [15:0] saturate(input logic [15:0] v,
                                             input logic ov,
                                             input logic a_sign);
        if (ov) begin
            saturate = a_sign ? 16'h8000 : 16'h7FFF;
        end else begin
            saturate = v;
        end
    endfunction

    assign op_s        = ex_r[3:0];
    assign mul_start_s = (state_r == IDLE) && valid_r && (op_s == OP_MUL);
    assign busy_s      = mul_start_s || (state_r == RUN);

    // ID/EX register: hold while multiplying, bubble on stall, otherwise load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_r <= 5'd0; m_r <= 2'd0; wb_r <= 7'd0;
            rs_r <= 16'd0; rt_r <= 16'd0; imm_r <= 16'd0; valid_r <= 1'b0;
        end else if (busy_s) begin
            ex_r <= ex_r;
        end else if (stall) begin
            ex_r <= 5'd0; m_r <= 2'd0; wb_r <= 7'd0;
            rs_r <= 16'd0; rt_r <= 16'd0; imm_r <= 16'd0; valid_r <= 1'b0;
        end else begin
            ex_r <= EX_in; m_r <= M_in; wb_r <= WB_in;
            rs_r <= rs_in; rt_r <= rt_in; imm_r <= imm_in; valid_r <= 1'b1;
        end
    end

    // ALU datapath and per-op flag update selection.
    always_comb begin
        b_s      = ex_r[4] ? imm_r : rt_r;
        shamt_s  = b_s[3:0];
        sum_s    = rs_r + b_s;
        diff_s   = rs_r - b_s;
        add_ov_s = (rs_r[15] == b_s[15]) && (sum_s[15] != rs_r[15]);
        sub_ov_s = (rs_r[15] != b_s[15]) && (diff_s[15] != rs_r[15]);
        result_s = 16'd0;
        upd_zn_s = 1'b0;
        upd_ov_s = 1'b0;
        ov_val_s = 1'b0;
        case (op_s)
            OP_ADD: begin
`ifdef EX_SAT_EN
                result_s = saturate(sum_s, add_ov_s, rs_r[15]);
`else
                result_s = sum_s;
`endif
                upd_zn_s = 1'b1; upd_ov_s = 1'b1; ov_val_s = add_ov_s;
            end
            OP_SUB: begin
`ifdef EX_SAT_EN
                result_s = saturate(diff_s, sub_ov_s, rs_r[15]);
`else
                result_s = diff_s;
`endif
                upd_zn_s = 1'b1; upd_ov_s = 1'b1; ov_val_s = sub_ov_s;
            end
            OP_AND: begin result_s = rs_r & b_s;    upd_zn_s = 1'b1; end
            OP_NOR: begin result_s = ~(rs_r | b_s); upd_zn_s = 1'b1; end
            OP_SLL: begin result_s = rs_r << shamt_s; upd_zn_s = 1'b1; end
            OP_SRL: begin result_s = rs_r >> shamt_s; upd_zn_s = 1'b1; end
            OP_SRA: begin result_s = $unsigned($signed(rs_r) >>> shamt_s); upd_zn_s = 1'b1; end
            OP_LHB: begin result_s = {imm_r[7:0], rs_r[7:0]}; end
            OP_LLB: begin result_s = {rs_r[15:8], imm_r[7:0]}; end
            OP_MUL: begin result_s = acc_r; upd_zn_s = 1'b1; end
            default: begin result_s = 16'd0; end
        endcase
    end

    // Visible flags: fresh bits from a valid instruction, held bits otherwise.
    always_comb begin
        flags_s = flag_r;
        if (valid_r && upd_zn_s) begin
            flags_s[1] = result_s[15];
            flags_s[0] = (result_s == 16'd0);
        end else begin
            flags_s[1:0] = flag_r[1:0];
        end
        if (valid_r && upd_ov_s) begin
            flags_s[2] = ov_val_s;
        end else begin
            flags_s[2] = flag_r[2];
        end
    end

    // Flag register commits when a valid instruction leaves the stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_r <= 3'd0;
        end else if (valid_r && !busy_s) begin
            flag_r <= flags_s;
        end
    end

    // Multiplier next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (mul_start_s) begin
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (cnt_r == CW'(MUL_CYCLES - 1)) begin
                    state_s = DONE;
                end else begin
                    state_s = RUN;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Multiplier state and shift-add datapath; the start cycle performs step 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            acc_r    <= 16'd0;
            mcand_r  <= 16'd0;
            mplier_r <= 16'd0;
            cnt_r    <= '0;
        end else begin
            state_r <= state_s;
            case (state_r)
                IDLE: begin
                    if (mul_start_s) begin
                        acc_r    <= rt_r[0] ? rs_r : 16'd0;
                        mcand_r  <= rs_r << 1;
                        mplier_r <= rt_r >> 1;
                        cnt_r    <= CW'(1);
                    end
                end
                RUN: begin
                    acc_r    <= acc_r + (mplier_r[0] ? mcand_r : 16'd0);
                    mcand_r  <= mcand_r << 1;
                    mplier_r <= mplier_r >> 1;
                    cnt_r    <= cnt_r + CW'(1);
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    assign ALU   = result_s;
    assign addr  = rs_r + imm_r;
    assign wdata = rt_r;
    assign flags = flags_s;
    assign M     = busy_s ? 2'd0 : m_r;
    assign WB    = busy_s ? 7'd0 : wb_r;
    assign busy  = busy_s;

endmodule

// File: tb/tb_ex_slice.sv
// Directed testbench for ex_slice; expected values are hand-computed.
module tb_ex_slice;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic [4:0]  EX_in = 5'd0;
    logic [1:0]  M_in = 2'd0;
    logic [6:0]  WB_in = 7'd0;
    logic [15:0] rs_in = 16'd0, rt_in = 16'd0, imm_in = 16'd0;
    logic [15:0] ALU, addr, wdata;
    logic [2:0]  flags;
    logic [1:0]  M;
    logic [6:0]  WB;
    logic        busy;

    int checks = 0;
    int errors = 0;

    ex_slice dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .EX_in(EX_in), .M_in(M_in),
        .WB_in(WB_in), .rs_in(rs_in), .rt_in(rt_in), .imm_in(imm_in),
        .ALU(ALU), .addr(addr), .wdata(wdata), .flags(flags), .M(M), .WB(WB),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] ex, input logic [1:0] m, input logic [6:0] wb,
                         input logic [15:0] rs, input logic [15:0] rt, input logic [15:0] imm);
        EX_in = ex; M_in = m; WB_in = wb; rs_in = rs; rt_in = rt; imm_in = imm;
    endtask

    task automatic test_reset();
        drive(5'h01, 2'b11, 7'h7F, 16'hAAAA, 16'h5555, 16'h1111);
        rst_n = 1'b0;
        tick();
        checks++;
        if ({ALU, addr, wdata, flags, M, WB, busy} !== {16'h0, 16'h0, 16'h0, 3'b000, 2'b00, 7'h00, 1'b0}) begin
            errors++;
            $display("FAIL reset: got ALU=%h addr=%h wdata=%h flags=%b M=%b WB=%h busy=%b, want all zero",
                     ALU, addr, wdata, flags, M, WB, busy);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_add_overflow();
        logic [15:0] exp_alu;
        logic [2:0]  exp_fl;
`ifdef EX_SAT_EN
        exp_alu = 16'h7FFF; exp_fl = 3'b100;
`else
        exp_alu = 16'h8000; exp_fl = 3'b110;
`endif
        drive(5'h00, 2'b01, 7'h55, 16'h7FFF, 16'h0001, 16'h0010);
        tick();
        checks++;
        if ({ALU, flags} !== {exp_alu, exp_fl}) begin
            errors++;
            $display("FAIL add_ovf: got ALU=%h flags=%b, want ALU=%h flags=%b", ALU, flags, exp_alu, exp_fl);
        end
        checks++;
        if ({addr, wdata, M, WB} !== {16'h800F, 16'h0001, 2'b01, 7'h55}) begin
            errors++;
            $display("FAIL add_pass: got addr=%h wdata=%h M=%b WB=%h, want 800f 0001 01 55", addr, wdata, M, WB);
        end
    endtask

    task automatic test_sub_and();
        drive(5'h01, 2'b00, 7'h11, 16'h1234, 16'h1234, 16'h0002);
        tick();
        checks++;
        if ({ALU, flags, addr} !== {16'h0000, 3'b001, 16'h1236}) begin
            errors++;
            $display("FAIL sub_zero: got ALU=%h flags=%b addr=%h, want 0000 001 1236", ALU, flags, addr);
        end
        drive(5'h02, 2'b00, 7'h12, 16'h00FF, 16'hFF00, 16'h0100);
        tick();
        checks++;
        if ({ALU, flags, addr} !== {16'h0000, 3'b001, 16'h01FF}) begin
            errors++;
            $display("FAIL and_zero: got ALU=%h flags=%b addr=%h, want 0000 001 01ff", ALU, flags, addr);
        end
    endtask

    task automatic test_shift();
        drive(5'h16, 2'b00, 7'h01, 16'h8000, 16'h0000, 16'h0004);
        tick();
        checks++;
        if ({ALU, flags} !== {16'hF800, 3'b010}) begin
            errors++;
            $display("FAIL sra: got ALU=%h flags=%b, want f800 010", ALU, flags);
        end
        drive(5'h15, 2'b00, 7'h02, 16'h8000, 16'h0000, 16'h0004);
        tick();
        checks++;
        if ({ALU, flags} !== {16'h0800, 3'b000}) begin
            errors++;
            $display("FAIL srl: got ALU=%h flags=%b, want 0800 000", ALU, flags);
        end
        drive(5'h17, 2'b00, 7'h03, 16'h00CD, 16'h0000, 16'h00AB);
        tick();
        checks++;
        if ({ALU, flags} !== {16'hABCD, 3'b000}) begin
            errors++;
            $display("FAIL lhb: got ALU=%h flags=%b, want abcd 000", ALU, flags);
        end
    endtask

    task automatic test_stall();
        drive(5'h00, 2'b10, 7'h2A, 16'hFFFF, 16'hFFFF, 16'h0000);
        tick();
        checks++;
        if ({ALU, flags, M, WB} !== {16'hFFFE, 3'b010, 2'b10, 7'h2A}) begin
            errors++;
            $display("FAIL add_neg: got ALU=%h flags=%b M=%b WB=%h, want fffe 010 10 2a", ALU, flags, M, WB);
        end
        stall = 1'b1;
        drive(5'h01, 2'b11, 7'h7F, 16'h0001, 16'h0001, 16'h0000);
        tick();
        stall = 1'b0;
        checks++;
        if ({M, WB, flags, ALU} !== {2'b00, 7'h00, 3'b010, 16'h0000}) begin
            errors++;
            $display("FAIL stall_bubble: got M=%b WB=%h flags=%b ALU=%h, want 00 00 010 0000", M, WB, flags, ALU);
        end
    endtask

    task automatic test_mul();
        int busy_seen;
        busy_seen = 0;
        drive(5'h09, 2'b10, 7'h3C, 16'h0003, 16'h0005, 16'h0000);
        tick();
        // next instruction waits at the input; stall during busy must be ignored
        drive(5'h00, 2'b01, 7'h44, 16'h8000, 16'h0030, 16'h0000);
        for (int i = 0; i < 16; i++) begin
            stall = (i < 4) ? 1'b1 : 1'b0;
            if (busy === 1'b1) busy_seen++;
            checks++;
            if ({busy, M, WB} !== {1'b1, 2'b00, 7'h00}) begin
                errors++;
                $display("FAIL mul_busy[%0d]: got busy=%b M=%b WB=%h, want 1 00 00", i, busy, M, WB);
            end
            tick();
        end
        stall = 1'b0;
        checks++;
        if ({busy, ALU, M, WB, flags} !== {1'b0, 16'h000F, 2'b10, 7'h3C, 3'b000}) begin
            errors++;
            $display("FAIL mul_done: got busy=%b ALU=%h M=%b WB=%h flags=%b, want 0 000f 10 3c 000",
                     busy, ALU, M, WB, flags);
        end
        checks++;
        if (busy_seen !== 16) begin
            errors++;
            $display("FAIL mul_busy_len: got %0d busy cycles, want 16", busy_seen);
        end
        tick();
        checks++;
        if ({busy, ALU, M, WB, flags} !== {1'b0, 16'h8030, 2'b01, 7'h44, 3'b010}) begin
            errors++;
            $display("FAIL mul_next: got busy=%b ALU=%h M=%b WB=%h flags=%b, want 0 8030 01 44 010",
                     busy, ALU, M, WB, flags);
        end
    endtask

    task automatic test_back_to_back();
        drive(5'h09, 2'b01, 7'h05, 16'h0100, 16'h0101, 16'h0000);
        tick();
        for (int i = 0; i < 16; i++) tick();
        checks++;
        if ({busy, ALU} !== {1'b0, 16'h0100}) begin
            errors++;
            $display("FAIL mul_b2b_a: got busy=%b ALU=%h, want 0 0100", busy, ALU);
        end
        drive(5'h09, 2'b01, 7'h06, 16'hFFFF, 16'h0002, 16'h0000);
        tick();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL mul_b2b_restart: got busy=%b, want 1", busy);
        end
        for (int i = 0; i < 16; i++) tick();
        checks++;
        if ({busy, ALU, flags} !== {1'b0, 16'hFFFE, 3'b010}) begin
            errors++;
            $display("FAIL mul_b2b_b: got busy=%b ALU=%h flags=%b, want 0 fffe 010", busy, ALU, flags);
        end
    endtask

    task automatic test_reset_mid_mul();
        drive(5'h09, 2'b11, 7'h33, 16'h0007, 16'h0009, 16'h0000);
        tick();                       // busy cycle 1
        for (int i = 0; i < 4; i++) tick();   // busy cycles 2..5
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL rmid_pre: got busy=%b, want 1", busy);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, ALU, M, WB, flags} !== {1'b0, 16'h0000, 2'b00, 7'h00, 3'b000}) begin
            errors++;
            $display("FAIL rmid_reset: got busy=%b ALU=%h M=%b WB=%h flags=%b, want all zero",
                     busy, ALU, M, WB, flags);
        end
        stall = 1'b1;
        drive(5'h00, 2'b11, 7'h7F, 16'h1234, 16'h4321, 16'h0F0F);
        #2;
        rst_n = 1'b1;
        tick();
        tick();
        checks++;
        if ({busy, ALU, M, WB, flags, addr, wdata} !== {1'b0, 16'h0000, 2'b00, 7'h00, 3'b000, 16'h0000, 16'h0000}) begin
            errors++;
            $display("FAIL rmid_after: got busy=%b ALU=%h M=%b WB=%h flags=%b addr=%h wdata=%h, want all zero",
                     busy, ALU, M, WB, flags, addr, wdata);
        end
        stall = 1'b0;
    endtask

    initial begin
        test_reset();
        test_add_overflow();
        test_sub_and();
        test_shift();
        test_stall();
        test_mul();
        test_back_to_back();
        test_reset_mid_mul();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
